screen_scanner: RTL and testbench
=================================

SCREEN_SCANNER -- requirements
Module: screen_scanner

Interface
REQ-001 Parameter BASE_ADDR, default 16384, SHALL be the first screen word address.
REQ-002 Parameter WORDS_PER_ROW, default 32, SHALL be the 16-bit words per pixel row.
REQ-003 Parameter ROWS, default 256, SHALL be the rows per frame; frame = WORDS_PER_ROW*ROWS words (8192).
REQ-004 clk  in  1  SHALL be the sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  SHALL be the reset; asynchronous, active-low.
REQ-006 enable  in  1  SHALL permit new memory reads when high.
REQ-007 restart  in  1  SHALL be a one-cycle pulse that resynchronises to frame start.
REQ-008 rd_req  out  1  SHALL be a one-cycle read request to the screen memory.
REQ-009 rd_addr  out  15  SHALL be the read address, valid when rd_req=1.
REQ-010 rd_data  in  16  SHALL be the returned word, sampled only when rd_valid=1.
REQ-011 rd_valid  in  1  SHALL flag rd_data valid, exactly once per rd_req, latency >=1 cycle.
REQ-012 pix  out  1  SHALL be the current pixel (1 = black).
REQ-013 pix_valid  out  1  SHALL flag pix valid.
REQ-014 pix_ready  in  1  SHALL accept a pixel; transfer = pix_valid & pix_ready.
REQ-015 pix_sof  out  1  SHALL be high with the frame's first pixel (word 0, bit 0).
REQ-016 pix_eol  out  1  SHALL be high with the row's last pixel (word col WORDS_PER_ROW-1, bit 15).

Function
REQ-017 Word counter wcnt (13 bits) SHALL give rd_addr = BASE_ADDR + wcnt; wcnt increments on each accepted rd_valid, wrapping 8191 -> 0.
REQ-018 Fetch FSM states SHALL be F_IDLE, F_REQ, F_WAIT, F_DISCARD.
REQ-019 F_IDLE -> F_REQ SHALL occur when enable=1, prefetch buffer empty, restart=0.
REQ-020 In F_REQ rd_req SHALL be 1 for exactly that one cycle; next state F_WAIT.
REQ-021 In F_WAIT, rd_valid=1 SHALL write rd_data into the prefetch buffer, set buf_full, increment wcnt, go to F_IDLE.
REQ-022 At most one read SHALL be outstanding; rd_req SHALL never assert in F_WAIT or F_DISCARD.
REQ-023 Shifter (16 bits + 5-bit count) SHALL load from the prefetch buffer when shifter empty and buf_full; same cycle clears buf_full.
REQ-024 A load and a buffer capture SHALL not coincide (capture requires empty buffer at request time); a load may coincide with the last pixel transfer of the previous word (no bubble).
REQ-025 pix SHALL equal shifter bit 0; bits SHALL emit LSB first (bit 0 = leftmost pixel); each transfer shifts right by one.
REQ-026 pix_valid SHALL be 1 while shifter holds >=1 unsent bit; shifter empties after 16 transfers.
REQ-027 pix, pix_sof, pix_eol SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-028 Each loaded word SHALL carry its word index; pix_sof/pix_eol derived from it, never from live wcnt.
REQ-029 With rd_valid latency 1 and pix_ready=1 continuously, pix_valid SHALL stay 1 with no gap after the first pixel.
REQ-030 enable=0 SHALL block new rd_req only; an outstanding read completes; buffered pixels drain; wcnt keeps its value.
REQ-031 restart=1 SHALL, next edge: wcnt=0, clear buf_full and shifter (pix_valid=0); from F_WAIT go to F_DISCARD, else F_IDLE.
REQ-032 F_DISCARD SHALL drop the next rd_valid data without touching wcnt or the buffer, then go to F_IDLE.
REQ-033 restart SHALL override a simultaneous rd_valid, load, or transfer.

Reset
REQ-034 rst_n=0 SHALL immediately force F_IDLE, wcnt=0, buffer and shifter empty, rd_req=0, rd_addr=BASE_ADDR, pix=0, pix_valid=0, pix_sof=0, pix_eol=0.
REQ-035 Reset mid-read SHALL abandon the read; the memory-side responder SHALL be reset together with this block.

Verification
REQ-036 Reset release, enable=1, 1-cycle memory, word 0 = 16'h0001 -> first rd_addr=16384; first pixel pix=1, pix_sof=1, next 15 pix=0.
REQ-037 Full frame, pix_ready=1, memory[a]=a -> 131072 pixels, pix_valid never drops after start, pix_eol every 512, wcnt wraps, pix_sof again at rd_addr=16384.
REQ-038 Word 31 = 16'h8000, random pix_ready -> pix_eol=1 only with its bit 15 (pix=1); outputs stable while stalled.
REQ-039 enable=0 during F_WAIT with 3-cycle latency -> read completes, no further rd_req, remaining 16-32 pixels drain, then pix_valid=0.
REQ-040 restart in F_WAIT, old rd_data=16'hFFFF -> data discarded, next rd_addr=16384, next pixel carries pix_sof=1 from word 0.
REQ-041 rst_n low mid-word -> all outputs 0 immediately; after release first rd_addr=16384.

Source files
------------

// File: rtl/screen_scanner.sv
// ---------------------------------------------------------------------------
// screen_scanner
//
// Streams a bitmapped monochrome frame buffer out as single pixels. The block
// fetches one 16-bit word at a time from screen memory and holds it in a
// one-word prefetch buffer. A 16-bit shifter emits the word's pixels LSB first.
// At most one read is outstanding at any time. Each word carries its own
// start-of-frame and end-of-row tags, so pix_sof and pix_eol stay correct
// however far the fetch side runs ahead of the pixel side.
//
// Ports
//   clk, rst_n    : clock (rising edge) and asynchronous active-low reset
//   enable        : allow new memory reads to start
//   restart       : one-cycle pulse; resynchronise to frame start
//   rd_req        : one-cycle read request, address on rd_addr
//   rd_addr[14:0] : BASE_ADDR + word counter
//   rd_data[15:0] : returned word, sampled only while rd_valid = 1
//   rd_valid      : one pulse per rd_req, at least one cycle after it
//   pix           : current pixel (1 = black)
//   pix_valid     : pix/pix_sof/pix_eol are meaningful
//   pix_ready     : sink accepts the pixel
//   pix_sof       : first pixel of the frame (word 0, bit 0)
//   pix_eol       : last pixel of a row (last word of the row, bit 15)
//   fetch_state   : current fetch FSM state, for debug and checkers
//
// Handshake: a pixel moves on a rising edge where pix_valid & pix_ready.
// While pix_valid = 1 and pix_ready = 0, pix, pix_sof and pix_eol hold
// steady. pix_valid never depends combinationally on pix_ready.
// ---------------------------------------------------------------------------
module screen_scanner #(
    parameter int BASE_ADDR     = 16384,
    parameter int WORDS_PER_ROW = 32,
    parameter int ROWS          = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        restart,
    output logic        rd_req,
    output logic [14:0] rd_addr,
    input  logic [15:0] rd_data,
    input  logic        rd_valid,
    output logic        pix,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic [1:0]  fetch_state
);

    localparam int FRAME_WORDS = WORDS_PER_ROW * ROWS;
    localparam int WCNT_W      = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int CCNT_W      = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_WORDS - 1);
    localparam logic [CCNT_W-1:0] LAST_COL  = CCNT_W'(WORDS_PER_ROW - 1);
    localparam logic [14:0]       BASE      = 15'(BASE_ADDR);

    typedef enum logic [1:0] {
        F_IDLE    = 2'd0,
        F_REQ     = 2'd1,
        F_WAIT    = 2'd2,
        F_DISCARD = 2'd3
    } fetch_state_t;

    fetch_state_t state, state_nx;

    // Word counter and its column position within the current row.
    logic [WCNT_W-1:0] wcnt;
    logic [CCNT_W-1:0] ccnt;

    // Prefetch buffer with its word tags.
    logic [15:0] buf_data;
    logic        buf_full;
    logic        buf_first;
    logic        buf_last;

    // Pixel shifter: sh_cnt is the number of unsent bits.
    logic [15:0] sh_data;
    logic [4:0]  sh_cnt;
    logic        sh_first;
    logic        sh_last;

    logic capture;
    logic load;
    logic xfer;

    // ------------------------------------------------------------------
    // Fetch FSM: next state and request output
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        rd_req   = 1'b0;
        case (state)
            F_IDLE:    if (enable && !buf_full && !restart) state_nx = F_REQ;
            F_REQ: begin
                rd_req   = 1'b1;
                state_nx = F_WAIT;
            end
            F_WAIT:    if (rd_valid) state_nx = F_IDLE;
            F_DISCARD: if (rd_valid) state_nx = F_IDLE;
            default:   state_nx = F_IDLE;
        endcase
        // On restart, a read that is still owed a response must be drained
        // in F_DISCARD. A request issued in this very cycle counts as owed.
        // A response that arrives with the restart pulse has already settled
        // the read, so the FSM returns to F_IDLE.
        if (restart) begin
            if (state == F_REQ || ((state == F_WAIT || state == F_DISCARD) && !rd_valid))
                state_nx = F_DISCARD;
            else
                state_nx = F_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= F_IDLE;
        else        state <= state_nx;
    end

    assign fetch_state = state;
    assign rd_addr     = BASE + 15'(wcnt);

    // ------------------------------------------------------------------
    // Datapath control
    // ------------------------------------------------------------------
    assign capture   = (state == F_WAIT) && rd_valid && !restart;
    assign pix_valid = (sh_cnt != 5'd0);
    assign xfer      = pix_valid && pix_ready;
    // The shifter reloads when it is empty. It also reloads in the same
    // cycle that its last bit leaves, so the pixel stream has no bubble.
    assign load      = buf_full && ((sh_cnt == 5'd0) || ((sh_cnt == 5'd1) && xfer));

    assign pix     = sh_data[0];
    assign pix_sof = pix_valid && sh_first && (sh_cnt == 5'd16);
    assign pix_eol = pix_valid && sh_last && (sh_cnt == 5'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt      <= '0;
            ccnt      <= '0;
            buf_data  <= '0;
            buf_full  <= 1'b0;
            buf_first <= 1'b0;
            buf_last  <= 1'b0;
            sh_data   <= '0;
            sh_cnt    <= '0;
            sh_first  <= 1'b0;
            sh_last   <= 1'b0;
        end else if (restart) begin
            // Restart wins over any capture, load or transfer in the same cycle.
            wcnt     <= '0;
            ccnt     <= '0;
            buf_full <= 1'b0;
            sh_data  <= '0;
            sh_cnt   <= '0;
            sh_first <= 1'b0;
            sh_last  <= 1'b0;
        end else begin
            if (capture) begin
                buf_data  <= rd_data;
                buf_first <= (wcnt == '0);
                buf_last  <= (ccnt == LAST_COL);
                wcnt      <= (wcnt == LAST_WORD) ? '0 : wcnt + WCNT_W'(1);
                ccnt      <= (ccnt == LAST_COL) ? '0 : ccnt + CCNT_W'(1);
            end

            // A capture needs an empty buffer when the request is made.
            // A load needs a full buffer. So the two never fall in the same cycle.
            if (capture)   buf_full <= 1'b1;
            else if (load) buf_full <= 1'b0;

            if (load) begin
                sh_data  <= buf_data;
                sh_cnt   <= 5'd16;
                sh_first <= buf_first;
                sh_last  <= buf_last;
            end else if (xfer) begin
                sh_data <= {1'b0, sh_data[15:1]};
                sh_cnt  <= sh_cnt - 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_screen_scanner.sv
// ---------------------------------------------------------------------------
// tb_screen_scanner
//
// Directed bench for screen_scanner. A small frame (4 rows of 32 words) keeps
// runs short. A memory responder returns words after a programmable latency.
// When a returned word is not being discarded, it pushes the word's 16
// expected pixels {pix, sof, eol} onto exp_q. A pixel monitor compares every
// valid pixel with the head of exp_q and pops it on transfer.
// ---------------------------------------------------------------------------
module tb_screen_scanner;

    localparam int BASE  = 16384;
    localparam int WPR   = 32;
    localparam int ROWS  = 4;
    localparam int FRAME = WPR * ROWS;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        restart;
    logic        rd_req;
    logic [14:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        pix;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic        pix_eol;
    logic [1:0]  fetch_state;

    screen_scanner #(
        .BASE_ADDR(BASE),
        .WORDS_PER_ROW(WPR),
        .ROWS(ROWS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .restart(restart),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .pix(pix),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_sof(pix_sof),
        .pix_eol(pix_eol),
        .fetch_state(fetch_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [2:0]  exp_q[$];
    logic [15:0] mem [FRAME];
    int          lat        = 1;
    int          pend_cnt   = 0;
    bit          pending    = 0;
    bit          drop       = 0;
    bit          forbid_req = 0;
    bit          gapless    = 0;
    bit          started    = 0;
    int          exp_addr   = BASE;
    int          req_addr   = BASE;
    int          words_done = 0;
    int          xfers      = 0;
    int          sof_seen   = 0;
    int          eol_seen   = 0;

    function automatic void check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endfunction

    // ---------------- memory responder (driver side) ----------------
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            rd_valid = 1'b0;
            pending  = 0;
            drop     = 0;
            pend_cnt = 0;
            exp_addr = BASE;
            exp_q.delete();
        end else begin
            rd_valid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    int widx;
                    widx     = req_addr - BASE;
                    rd_valid = 1'b1;
                    rd_data  = mem[widx];
                    pending  = 0;
                    if (!drop && !restart) begin
                        for (int b = 0; b < 16; b++)
                            exp_q.push_back({mem[widx][b], (widx == 0 && b == 0),
                                             ((widx % WPR) == WPR - 1 && b == 15)});
                        exp_addr = ((exp_addr - BASE + 1) % FRAME) + BASE;
                        words_done++;
                    end
                    drop = 0;
                end
            end
            if (forbid_req) check("no_rd_req", 32'(rd_req), 32'd0);
            if (rd_req) begin
                check("rd_addr", 32'(rd_addr), 32'(exp_addr));
                check("one_outstanding", 32'(pending), 32'd0);
                pending  = 1;
                pend_cnt = lat;
                req_addr = int'(rd_addr);
            end
            if (restart) begin
                exp_q.delete();
                exp_addr = BASE;
                if (pending) drop = 1;
            end
        end
    end

    // ---------------- pixel monitor ----------------
    always begin
        @(negedge clk);
        #2;
        if (rst_n && !restart) begin
            if (pix_valid) begin
                if (exp_q.size() == 0) begin
                    check("pix_unexpected", 32'(pix_valid), 32'd0);
                end else begin
                    check("pix_out", 32'({pix, pix_sof, pix_eol}), 32'(exp_q[0]));
                    if (pix_ready) begin
                        void'(exp_q.pop_front());
                        xfers++;
                        if (pix_sof) sof_seen++;
                        if (pix_eol) eol_seen++;
                        if (gapless) started = 1;
                    end
                end
            end else if (gapless && started) begin
                check("no_gap", 32'(pix_valid), 32'd1);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic drain(input string tag);
        enable    = 1'b0;
        pix_ready = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (!pix_valid && !pending && (fetch_state == 2'd0)) break;
        end
        @(negedge clk);
        check({tag, "_drained"}, 32'(pix_valid), 32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_second_req(input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd_req && rd_addr != 15'(BASE)) begin
                found = 1;
                break;
            end
        end
        check({tag, "_second_req"}, 32'(found), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        restart   = 1'b0;
        pix_ready = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = 16'h0000;
        for (int i = 0; i < FRAME; i++) mem[i] = 16'(BASE + i);

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'(BASE));
        check("rst_pix", 32'(pix), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_sof", 32'(pix_sof), 32'd0);
        check("rst_eol", 32'(pix_eol), 32'd0);
        check("rst_state", 32'(fetch_state), 32'd0);
        rst_n = 1'b1;

        // First word, then a full frame plus wrap, gapless at latency 1
        mem[0]    = 16'h0001;
        lat       = 1;
        pix_ready = 1'b1;
        gapless   = 1;
        started   = 0;
        sof_seen  = 0;
        eol_seen  = 0;
        words_done = 0;
        @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 20 && !pix_valid; i++) @(negedge clk);
        check("first_pix_valid", 32'(pix_valid), 32'd1);
        check("first_pix", 32'(pix), 32'd1);
        check("first_sof", 32'(pix_sof), 32'd1);
        for (int i = 0; i < 3000 && words_done < FRAME + 2; i++) @(negedge clk);
        check("frame_words", 32'(words_done >= FRAME + 2), 32'd1);
        gapless = 0;
        drain("frame");
        check("frame_sof_count", 32'(sof_seen), 32'd2);
        check("frame_eol_count", 32'(eol_seen), 32'(ROWS));

        // Random back-pressure and latency, word 31 = 16'h8000
        pulse_restart();
        mem[31]    = 16'h8000;
        words_done = 0;
        eol_seen   = 0;
        enable     = 1'b1;
        for (int i = 0; i < 3000 && words_done < 40; i++) begin
            @(negedge clk);
            pix_ready = 1'($urandom_range(0, 1));
            lat       = $urandom_range(1, 3);
        end
        check("stall_words", 32'(words_done >= 40), 32'd1);
        drain("stall");
        check("stall_eol_count", 32'(eol_seen), 32'd1);

        // Restart while a read is in flight; stale 16'hFFFF must be dropped
        pulse_restart();
        for (int i = 0; i < FRAME; i++) mem[i] = 16'hFFFF;
        mem[0]    = 16'hA5C3;
        lat       = 3;
        pix_ready = 1'b1;
        enable    = 1'b1;
        wait_second_req("rst_wait");
        @(negedge clk);
        check("rs_in_wait", 32'(fetch_state), 32'd2);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("rs_discard", 32'(fetch_state), 32'd3);
        check("rs_pix_cleared", 32'(pix_valid), 32'd0);
        for (int i = 0; i < 40 && !pix_valid; i++) @(negedge clk);
        check("rs_pix_valid", 32'(pix_valid), 32'd1);
        check("rs_pix", 32'(pix), 32'd1);
        check("rs_sof", 32'(pix_sof), 32'd1);
        drain("restart");

        // enable = 0 during F_WAIT at latency 3: read completes, pixels drain
        pulse_restart();
        for (int i = 0; i < FRAME; i++) mem[i] = 16'(BASE + i);
        lat    = 3;
        enable = 1'b1;
        wait_second_req("en_wait");
        @(negedge clk);
        check("en_in_wait", 32'(fetch_state), 32'd2);
        enable     = 1'b0;
        forbid_req = 1;
        begin
            int x0;
            int drained;
            x0 = xfers;
            for (int i = 0; i < 100 && (pix_valid || pending || fetch_state != 2'd0); i++)
                @(negedge clk);
            @(negedge clk);
            drained = xfers - x0;
            check("en_drain_range", 32'(drained >= 16 && drained <= 32), 32'd1);
        end
        check("en_pix_valid_off", 32'(pix_valid), 32'd0);
        check("en_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (20) @(negedge clk);
        check("en_wcnt_hold", 32'(rd_addr), 32'(BASE + 2));
        forbid_req = 0;

        // Asynchronous reset in the middle of a word
        enable = 1'b1;
        lat    = 1;
        for (int i = 0; i < 40 && !pix_valid; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_rd_req", 32'(rd_req), 32'd0);
        check("arst_rd_addr", 32'(rd_addr), 32'(BASE));
        check("arst_pix", 32'(pix), 32'd0);
        check("arst_pix_valid", 32'(pix_valid), 32'd0);
        check("arst_sof", 32'(pix_sof), 32'd0);
        check("arst_eol", 32'(pix_eol), 32'd0);
        check("arst_state", 32'(fetch_state), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40 && !pix_valid; i++) @(negedge clk);
        check("arst_restart_valid", 32'(pix_valid), 32'd1);
        check("arst_restart_sof", 32'(pix_sof), 32'd1);
        drain("arst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
